sudoku_propagator: RTL and testbench

Parametrised constraint-propagation core for N×N Sudoku grids (N = p_BOX²), sitting between the UART grid reader and the UART transmitter. It accepts givens one cell per cycle, sweeps the grid cell by cycle with elimination of peer singletons until the grid is solved, stalls, or contradicts itself. It then streams the result digits row-major over a valid/ready handshake. It adds three things the fixed 9×9 combinational scanner lacks: configurable box size, conflict and stall detection, and output backpressure.

---
 rtl/sudoku_pkg.sv | 53 +++++
 rtl/sudoku_propagator_if.sv | 38 +++
 rtl/sudoku_peer_mask.sv | 37 +++
 rtl/sudoku_propagator.sv | 157 +++++++++++++++
 tb/tb_sudoku_propagator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku constraint-propagation core.
// Grid geometry is derived from the box edge through the sizing functions.
package sudoku_pkg;

  localparam int unsigned MAX_N = 16;

  typedef logic [MAX_N-1:0] mask_t;
  typedef logic [4:0]       digit_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_SWEEP,
    S_CHECK,
    S_STREAM,
    S_DONE
  } state_t;

  function automatic int unsigned grid_n(input int unsigned box);
    return box * box;
  endfunction

  function automatic int unsigned digit_w(input int unsigned box);
    return $clog2(box * box + 1);
  endfunction

  function automatic int unsigned cell_w(input int unsigned box);
    return $clog2(box * box * box * box);
  endfunction

  function automatic logic is_singleton(input mask_t m);
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

  function automatic digit_t onehot_to_digit(input mask_t m);
    digit_t d = '0;
    if (is_singleton(m)) begin
      for (int unsigned i = 0; i < MAX_N; i++) begin
        if (m[i]) d = 5'(i + 1);
      end
    end
    return d;
  endfunction

  // Out-of-range digits load as a blank (every candidate of an n-wide grid).
  function automatic mask_t digit_to_mask(input digit_t d, input int unsigned n);
    if (d != '0 && 32'(d) <= n) return mask_t'(1) << (d - 1'b1);
    if (n >= MAX_N) return '1;
    return (mask_t'(1) << n) - 1'b1;
  endfunction

endpackage

// File: rtl/sudoku_propagator_if.sv
// Load, start, result-stream and status signals of the propagator core.
// The core takes the slave modport; the feeding/consuming side takes master.
interface sudoku_propagator_if
  import sudoku_pkg::*;
#(
  parameter int unsigned p_BOX        = 3,
  parameter int unsigned p_MAX_PASSES = 32
) ();

  localparam int unsigned W  = digit_w(p_BOX);
  localparam int unsigned PW = $clog2(p_MAX_PASSES + 1);

  logic          i_Load_Valid;
  logic [W-1:0]  i_Load_Digit;
  logic          i_Start;
  logic          o_Out_Valid;
  logic [W-1:0]  o_Out_Digit;
  logic          i_Out_Ready;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Solved;
  logic          o_Stuck;
  logic          o_Conflict;
  logic [PW-1:0] o_Pass_Count;

  modport master (
    output i_Load_Valid, i_Load_Digit, i_Start, i_Out_Ready,
    input  o_Out_Valid, o_Out_Digit, o_Busy, o_Done,
           o_Solved, o_Stuck, o_Conflict, o_Pass_Count
  );

  modport slave (
    input  i_Load_Valid, i_Load_Digit, i_Start, i_Out_Ready,
    output o_Out_Valid, o_Out_Digit, o_Busy, o_Done,
           o_Solved, o_Stuck, o_Conflict, o_Pass_Count
  );

endinterface

// File: rtl/sudoku_peer_mask.sv
// OR of the candidate masks of every resolved (singleton) peer of one cell:
// same row, column or box, the cell itself excluded.
module sudoku_peer_mask
  import sudoku_pkg::*;
#(
  parameter  int unsigned p_BOX = 3,
  localparam int unsigned N     = grid_n(p_BOX),
  localparam int unsigned CW    = cell_w(p_BOX)
) (
  input  logic [N-1:0]  masks [N*N],
  input  logic [CW-1:0] idx,
  output logic [N-1:0]  peers
);

  int unsigned self_idx, row, col, box_row, box_col;
  int unsigned cand [3];

  always_comb begin
    peers    = '0;
    self_idx = 32'(idx);
    row      = self_idx / N;
    col      = self_idx % N;
    box_row  = (row / p_BOX) * p_BOX;
    box_col  = (col / p_BOX) * p_BOX;
    cand     = '{0, 0, 0};
    for (int unsigned k = 0; k < N; k++) begin
      cand[0] = row * N + k;
      cand[1] = k * N + col;
      cand[2] = (box_row + k / p_BOX) * N + box_col + k % p_BOX;
      for (int unsigned s = 0; s < 3; s++) begin
        if (cand[s] != self_idx && is_singleton(mask_t'(masks[CW'(cand[s])])))
          peers = peers | masks[CW'(cand[s])];
      end
    end
  end

endmodule

// File: rtl/sudoku_propagator.sv
// Sudoku constraint-propagation core: load givens, sweep peer-singleton
// elimination pass by pass, then stream the resulting digits row-major.
module sudoku_propagator
  import sudoku_pkg::*;
#(
  parameter int unsigned p_BOX        = 3,
  parameter int unsigned p_MAX_PASSES = 32
) (
  input logic                i_Clk,
  input logic                i_Rst,
  sudoku_propagator_if.slave bus
);

  localparam int unsigned N     = grid_n(p_BOX);
  localparam int unsigned W     = digit_w(p_BOX);
  localparam int unsigned CW    = cell_w(p_BOX);
  localparam int unsigned PW    = $clog2(p_MAX_PASSES + 1);
  localparam int unsigned CELLS = N * N;
  localparam logic [CW-1:0] LAST = CW'(CELLS - 1);

  state_t        state;
  logic [N-1:0]  mask [CELLS];
  logic [CW-1:0] ld_idx, sw_idx, out_idx;
  logic          changed, conflict_pass;
  logic          out_valid, busy, done, solved, stuck, conflict;
  logic [W-1:0]  out_digit;
  logic [PW-1:0] pass_count;

  logic [N-1:0]  peers, cur_mask, new_mask, load_mask;
  logic [PW-1:0] pass_next;
  logic [CW-1:0] out_next;
  logic          all_single;

  function automatic logic [W-1:0] cell_digit(input logic [N-1:0] m);
    return W'(onehot_to_digit(mask_t'(m)));
  endfunction

  sudoku_peer_mask #(.p_BOX(p_BOX)) u_peer (
    .masks (mask),
    .idx   (sw_idx),
    .peers (peers)
  );

  always_comb begin
    cur_mask   = mask[sw_idx];
    new_mask   = cur_mask & ~peers;
    load_mask  = N'(digit_to_mask(5'(bus.i_Load_Digit), N));
    pass_next  = pass_count + 1'b1;
    out_next   = out_idx + 1'b1;
    all_single = 1'b1;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (!is_singleton(mask_t'(mask[CW'(i)]))) all_single = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= S_IDLE;
      ld_idx        <= '0;
      sw_idx        <= '0;
      out_idx       <= '0;
      changed       <= 1'b0;
      conflict_pass <= 1'b0;
      out_valid     <= 1'b0;
      out_digit     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      solved        <= 1'b0;
      stuck         <= 1'b0;
      conflict      <= 1'b0;
      pass_count    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.i_Load_Valid) begin
            mask[0]    <= load_mask;
            ld_idx     <= CW'(1);
            solved     <= 1'b0;
            stuck      <= 1'b0;
            conflict   <= 1'b0;
            pass_count <= '0;
            done       <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.i_Load_Valid) begin
            mask[ld_idx] <= load_mask;
            if (ld_idx == LAST) state <= S_LOADED;
            else                ld_idx <= ld_idx + 1'b1;
          end
        end
        S_LOADED: begin
          if (bus.i_Start) begin
            changed       <= 1'b0;
            conflict_pass <= 1'b0;
            sw_idx        <= '0;
            busy          <= 1'b1;
            state         <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          mask[sw_idx] <= new_mask;
          if (new_mask != cur_mask) changed <= 1'b1;
          if (new_mask == '0)       conflict_pass <= 1'b1;
          if (sw_idx == LAST) state <= S_CHECK;
          else                sw_idx <= sw_idx + 1'b1;
        end
        S_CHECK: begin
          pass_count <= pass_next;
          if (conflict_pass) begin
            conflict <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (!all_single && changed && pass_next < PW'(p_MAX_PASSES)) begin
            changed <= 1'b0;
            sw_idx  <= '0;
            state   <= S_SWEEP;
          end else begin
            solved    <= all_single;
            stuck     <= !all_single;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_digit <= cell_digit(mask[0]);
            state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_valid && bus.i_Out_Ready) begin
            if (out_idx == LAST) begin
              out_valid <= 1'b0;
              out_digit <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              out_idx   <= out_next;
              out_digit <= cell_digit(mask[out_next]);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Out_Valid  = out_valid;
  assign bus.o_Out_Digit  = out_digit;
  assign bus.o_Busy       = busy;
  assign bus.o_Done       = done;
  assign bus.o_Solved     = solved;
  assign bus.o_Stuck      = stuck;
  assign bus.o_Conflict   = conflict;
  assign bus.o_Pass_Count = pass_count;

endmodule

// File: tb/tb_sudoku_propagator.sv
// Directed bench for the propagator: a 4x4 core for the small grid cases and
// a 9x9 core for the full-size puzzle, both checked against known solutions.
module tb_sudoku_propagator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sudoku_propagator_if #(.p_BOX(2), .p_MAX_PASSES(32)) bus2 ();
  sudoku_propagator_if #(.p_BOX(3), .p_MAX_PASSES(32)) bus3 ();

  sudoku_propagator #(.p_BOX(2), .p_MAX_PASSES(32)) dut2 (.i_Clk(clk), .i_Rst(rst), .bus(bus2));
  sudoku_propagator #(.p_BOX(3), .p_MAX_PASSES(32)) dut3 (.i_Clk(clk), .i_Rst(rst), .bus(bus3));

  int n_checks = 0;
  int n_errors = 0;

  int sol4 [16] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
  int zero4 [16] = '{default: 0};
  int sol9 [81] = '{5,3,4,6,7,8,9,1,2,
                    6,7,2,1,9,5,3,4,8,
                    1,9,8,3,4,2,5,6,7,
                    8,5,9,7,6,1,4,2,3,
                    4,2,6,8,5,3,7,9,1,
                    7,1,3,9,2,4,8,5,6,
                    9,6,1,5,3,7,2,8,4,
                    2,8,7,4,1,9,6,3,5,
                    3,4,5,2,8,6,1,7,9};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_4x4"}, {bus2.o_Out_Valid, bus2.o_Busy, bus2.o_Done, bus2.o_Solved, bus2.o_Stuck,
                          bus2.o_Conflict, bus2.o_Pass_Count, bus2.o_Out_Digit}, 0);
    check({tag, "_9x9"}, {bus3.o_Out_Valid, bus3.o_Busy, bus3.o_Done, bus3.o_Solved, bus3.o_Stuck,
                          bus3.o_Conflict, bus3.o_Pass_Count, bus3.o_Out_Digit}, 0);
  endtask

  // A start pulse mid-load must be ignored.
  task automatic load4(input int g [16]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 9) begin
        check("start_in_load", bus2.o_Busy, 0);
        bus2.i_Start = 1'b0;
      end
      if (i == 8) bus2.i_Start = 1'b1;
      bus2.i_Load_Valid = 1'b1;
      bus2.i_Load_Digit = 3'(g[i]);
    end
    @(negedge clk);
    bus2.i_Load_Valid = 1'b0;
    bus2.i_Load_Digit = '0;
  endtask

  // Start, then wait for stream or done; junk drives load beats while sweeping.
  task automatic run4(input string tag, input int exp_lat, input bit junk);
    int cyc = 0;
    bus2.i_Start = 1'b1;
    do begin
      @(negedge clk);
      bus2.i_Start = 1'b0;
      cyc++;
      if (junk) begin
        bus2.i_Load_Valid = 1'b1;
        bus2.i_Load_Digit = 3'd1;
      end
    end while (!(bus2.o_Out_Valid || bus2.o_Done) && cyc < 500);
    bus2.i_Load_Valid = 1'b0;
    bus2.i_Load_Digit = '0;
    check({tag, "_latency"}, cyc, exp_lat);
  endtask

  task automatic stream4(input string tag, input int exp [16], input bit toggle);
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   got_n = 0;
    int   cyc = 0;
    bit   stalled = 1'b0;
    bit   rdy;
    logic [2:0] held = '0;
    while (got_n < 16 && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        check({tag, "_hold_digit"}, bus2.o_Out_Digit, held);
        check({tag, "_hold_valid"}, bus2.o_Out_Valid, 1);
      end
      rdy = toggle ? pat[cyc % 4] : 1'b1;
      cyc++;
      bus2.i_Out_Ready = rdy;
      stalled = 1'b0;
      if (bus2.o_Out_Valid) begin
        if (rdy) begin
          check($sformatf("%s_digit%0d", tag, got_n), bus2.o_Out_Digit, exp[got_n]);
          got_n++;
        end else begin
          stalled = 1'b1;
          held    = bus2.o_Out_Digit;
        end
      end
    end
    @(negedge clk);
    bus2.i_Out_Ready = 1'b0;
    check({tag, "_beats"}, got_n, 16);
    check({tag, "_done_valid_busy"}, {bus2.o_Done, bus2.o_Out_Valid, bus2.o_Busy}, 3'b100);
  endtask

  task automatic flags4(input string tag, input logic [2:0] exp_flags, input int exp_pc);
    check({tag, "_solved_stuck_conflict"}, {bus2.o_Solved, bus2.o_Stuck, bus2.o_Conflict}, exp_flags);
    check({tag, "_passes"}, bus2.o_Pass_Count, exp_pc);
  endtask

  // One blank per row, column and box; cell 0 loads an out-of-range digit.
  task automatic load9();
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      bus3.i_Load_Valid = 1'b1;
      if (i % 9 == (3 * (i / 9) + (i / 9) / 3) % 9)
        bus3.i_Load_Digit = (i == 0) ? 4'd12 : 4'd0;
      else
        bus3.i_Load_Digit = 4'(sol9[i]);
    end
    @(negedge clk);
    bus3.i_Load_Valid = 1'b0;
    bus3.i_Load_Digit = '0;
  endtask

  task automatic solve9();
    int cyc = 0;
    int got_n = 0;
    bus3.i_Start = 1'b1;
    do begin
      @(negedge clk);
      bus3.i_Start = 1'b0;
      cyc++;
    end while (!(bus3.o_Out_Valid || bus3.o_Done) && cyc < 3000);
    check("p9_latency", cyc, 83);
    check("p9_solved", bus3.o_Solved, 1);
    check("p9_passes", bus3.o_Pass_Count, 1);
    check("p9_pass_limit", (bus3.o_Pass_Count <= 32) ? 1 : 0, 1);
    cyc = 0;
    while (got_n < 81 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus3.i_Out_Ready = 1'b1;
      if (bus3.o_Out_Valid) begin
        check($sformatf("p9_digit%0d", got_n), bus3.o_Out_Digit, sol9[got_n]);
        got_n++;
      end
    end
    @(negedge clk);
    bus3.i_Out_Ready = 1'b0;
    check("p9_beats", got_n, 81);
    check("p9_done", bus3.o_Done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g [16];
    bus2.i_Load_Valid = 1'b0; bus2.i_Load_Digit = '0; bus2.i_Start = 1'b0; bus2.i_Out_Ready = 1'b0;
    bus3.i_Load_Valid = 1'b0; bus3.i_Load_Digit = '0; bus3.i_Start = 1'b0; bus3.i_Out_Ready = 1'b0;
    repeat (3) @(negedge clk);
    idle_check("reset");
    rst = 1'b0;

    // Two blanks (one as an over-range digit) resolved in a single pass.
    g = sol4; g[0] = 7; g[15] = 0;
    load4(g);
    run4("t1", 18, 1'b0);
    stream4("t1", sol4, 1'b0);
    flags4("t1", 3'b100, 1);

    // Nothing to propagate.
    load4(zero4);
    run4("t2", 18, 1'b0);
    stream4("t2", zero4, 1'b0);
    flags4("t2", 3'b010, 1);

    // Duplicate givens in row 0.
    g = zero4; g[0] = 1; g[1] = 1;
    load4(g);
    run4("t3", 18, 1'b0);
    flags4("t3", 3'b001, 1);
    check("t3_done_valid_busy", {bus2.o_Done, bus2.o_Out_Valid, bus2.o_Busy}, 3'b100);
    bus2.i_Out_Ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_no_stream", bus2.o_Out_Valid, 0);
    bus2.i_Out_Ready = 1'b0;

    // Row 0 and column 0 blank: cell 0 only resolves on the second pass.
    g = sol4; g[0] = 0; g[1] = 0; g[2] = 0; g[3] = 0; g[4] = 0; g[8] = 0; g[12] = 0;
    load4(g);
    run4("t4", 35, 1'b1);
    stream4("t4", sol4, 1'b1);
    flags4("t4", 3'b100, 2);

    // Reset mid-sweep.
    g = sol4; g[0] = 0; g[15] = 0;
    load4(g);
    bus2.i_Start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus2.i_Start = 1'b0;
    end
    check("t5_busy_before_rst", bus2.o_Busy, 1);
    rst = 1'b1;
    @(negedge clk);
    idle_check("t5_rst_sweep");
    rst = 1'b0;

    // Reset mid-stream.
    load4(zero4);
    run4("t5b", 18, 1'b0);
    repeat (3) begin
      @(negedge clk);
      bus2.i_Out_Ready = 1'b1;
    end
    @(negedge clk);
    check("t5_valid_before_rst", bus2.o_Out_Valid, 1);
    bus2.i_Out_Ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    idle_check("t5_rst_stream");
    rst = 1'b0;

    g = sol4; g[0] = 0; g[15] = 0;
    load4(g);
    run4("t5c", 18, 1'b0);
    stream4("t5c", sol4, 1'b0);
    flags4("t5c", 3'b100, 1);

    load9();
    solve9();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
